// File: rtl/mem_stage_ctrl.sv
// MEM stage sequencer: one req/ready access per load/store, freezing the pipe until retire.
// Optional MEM_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT cycles and sets a sticky error.
module mem_stage_ctrl #(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int          ADDR_W    = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       st_val,
  output logic              freeze,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_pend;
  logic [31:0]       w_diff;
  logic              w_freeze;
  logic              w_done;
  logic              w_issue;
  logic              w_tout;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd;

  assign w_pend  = mem_r_en | mem_w_en;
  assign w_diff  = alu_result - 32'(ADDR_BASE);
  assign w_issue = (r_state == S_IDLE) && w_pend;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_err;

  // Count resets outside WAIT so every access starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= '0;
    end else if (!mem_ready) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_tout = (r_state == S_WAIT) && !mem_ready && (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_tout) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;

  logic w_unused;
  assign w_unused = ^{w_diff[31:ADDR_W+2], w_diff[1:0]};
`else
  assign w_tout  = 1'b0;
  assign mem_err = 1'b0;

  logic w_unused;
  assign w_unused = ^{w_diff[31:ADDR_W+2], w_diff[1:0], 32'(TIMEOUT)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_freeze = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pend) begin
          w_freeze = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_freeze = 1'b1;
        if (mem_ready || w_tout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Gate with rst so the pipeline is released the instant reset rises.
  assign freeze = w_freeze & ~rst;
  assign done   = w_done & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= mem_w_en;
      r_addr  <= w_diff[ADDR_W+1:2];
      r_wdata <= st_val;
    end else if (r_state == S_WAIT) begin
      if (mem_ready) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_rd <= mem_rdata;
        end
      end else if (w_tout) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_rd <= '0;
        end
      end
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rd_data   = r_rd;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reads, writes, back-to-back, both-enables,
// stray ready, address wrap, hang/timeout and asynchronous reset mid-transaction.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic        freeze;
  logic [31:0] rd_data;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_BASE(1024),
    .ADDR_W   (16),
    .TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .alu_result(alu_result),
    .st_val    (st_val),
    .freeze    (freeze),
    .rd_data   (rd_data),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nd0;
  int nf;

  initial begin
    rst        = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    alu_result = '0;
    st_val     = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_req",    32'(mem_req), 0);
    chk("rst_we",     32'(mem_we), 0);
    chk("rst_addr",   32'(mem_addr), 0);
    chk("rst_wdata",  mem_wdata, 0);
    chk("rst_rd",     rd_data, 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_err",    32'(mem_err), 0);
    tick();
    rst = 1'b0;

    // Read, ready on the 3rd WAIT cycle
    tick();
    mem_r_en = 1'b1; alu_result = 32'd1032;
    #1;
    chk("rd_c0_freeze", 32'(freeze), 1);
    chk("rd_c0_req",    32'(mem_req), 0);
    tick(); #1;
    chk("rd_w1_req",    32'(mem_req), 1);
    chk("rd_w1_addr",   32'(mem_addr), 2);
    chk("rd_w1_we",     32'(mem_we), 0);
    chk("rd_w1_freeze", 32'(freeze), 1);
    tick(); #1;
    chk("rd_w2_freeze", 32'(freeze), 1);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("rd_w3_freeze", 32'(freeze), 1);
    chk("rd_w3_done",   32'(done), 0);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rd_done",      32'(done), 1);
    chk("rd_dn_freeze", 32'(freeze), 0);
    chk("rd_dn_req",    32'(mem_req), 0);
    chk("rd_data",      rd_data, 32'h12345678);
    tick();
    mem_r_en = 1'b0;
    #1;
    chk("rd_post_done", 32'(done), 0);

    // Write, ready on the 1st WAIT cycle
    tick();
    mem_w_en = 1'b1; alu_result = 32'd1028; st_val = 32'hA5A5A5A5;
    #1;
    chk("wr_c0_freeze", 32'(freeze), 1);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("wr_we",        32'(mem_we), 1);
    chk("wr_addr",      32'(mem_addr), 1);
    chk("wr_wdata",     mem_wdata, 32'hA5A5A5A5);
    chk("wr_req",       32'(mem_req), 1);
    chk("wr_w1_freeze", 32'(freeze), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("wr_done",      32'(done), 1);
    chk("wr_dn_freeze", 32'(freeze), 0);
    chk("wr_rd_keep",   rd_data, 32'h12345678);
    tick();
    mem_w_en = 1'b0;
    #1;
    chk("wr_post_done", 32'(done), 0);

    // Back-to-back loads
    nd0 = n_done;
    tick();
    mem_r_en = 1'b1; alu_result = 32'd1040;
    tick();
    chk("bb1_addr", 32'(mem_addr), 4);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0011;
    tick();
    mem_ready = 1'b0;
    alu_result = 32'd1043;
    #1;
    chk("bb1_done", 32'(done), 1);
    chk("bb1_rd",   rd_data, 32'h11);
    tick(); #1;
    chk("bb2_idle_freeze", 32'(freeze), 1);
    chk("bb2_idle_req",    32'(mem_req), 0);
    tick();
    chk("bb2_req",  32'(mem_req), 1);
    chk("bb2_addr", 32'(mem_addr), 4);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0022;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("bb2_done", 32'(done), 1);
    chk("bb2_rd",   rd_data, 32'h22);
    tick();
    mem_r_en = 1'b0;
    tick(); tick();
    chk("bb_pulses", 32'(n_done - nd0), 2);

    // Both enables: write wins
    mem_r_en = 1'b1; mem_w_en = 1'b1;
    alu_result = 32'd1036; st_val = 32'hDEADBEEF;
    tick();
    chk("both_we",    32'(mem_we), 1);
    chk("both_addr",  32'(mem_addr), 3);
    chk("both_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("both_done", 32'(done), 1);
    chk("both_rd",   rd_data, 32'h22);
    tick();
    mem_r_en = 1'b0; mem_w_en = 1'b0;

    // Stray ready while idle
    nd0 = n_done;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h99;
    #1;
    chk("stray_freeze", 32'(freeze), 0);
    tick(); #1;
    chk("stray_req",  32'(mem_req), 0);
    chk("stray_rd",   rd_data, 32'h22);
    tick();
    mem_ready = 1'b0;
    chk("stray_done", 32'(n_done - nd0), 0);

    // Underflowing address wraps
    mem_r_en = 1'b1; alu_result = 32'd0;
    tick();
    chk("wrap_addr", 32'(mem_addr), 32'hFF00);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_ready = 1'b0;
    chk("wrap_rd", rd_data, 32'hCAFE0001);
    tick();
    mem_r_en = 1'b0;
    tick();

    // No ready at all
    mem_r_en = 1'b1; alu_result = 32'd1024;
`ifdef MEM_TIMEOUT_EN
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req) nf++;
    end
    chk("to_req_cycles", 32'(nf), 8);
    tick();
    chk("to_req",  32'(mem_req), 0);
    chk("to_err",  32'(mem_err), 1);
    chk("to_done", 32'(done), 1);
    chk("to_rd",   rd_data, 0);
    tick();
    chk("to_err_sticky", 32'(mem_err), 1);
    tick();
`else
    nf = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (freeze) nf++;
    end
    chk("hang_freeze", 32'(nf), 120);
    chk("hang_req",    32'(mem_req), 1);
    chk("hang_err",    32'(mem_err), 0);
`endif

    // Asynchronous reset mid-transaction
    #2 rst = 1'b1;
    #1;
    chk("arst_freeze", 32'(freeze), 0);
    chk("arst_req",    32'(mem_req), 0);
    chk("arst_rd",     rd_data, 0);
    chk("arst_done",   32'(done), 0);
    chk("arst_err",    32'(mem_err), 0);
    mem_r_en = 1'b0;
    tick();
    rst = 1'b0;
    tick(); #1;
    chk("post_rst_freeze", 32'(freeze), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
